// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage.
// Optional feature macro used by this slice: MEM_ALIGN_CHK_EN.
package mem_stage_pkg;

    localparam int DataWidth    = 16;
    localparam int RegAddrWidth = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } stateT;

    // Everything the execute stage hands over for one operation.
    typedef struct packed {
        logic [DataWidth-1:0]    aluRes;
        logic [DataWidth-1:0]    rt;
        logic                    regWrite;
        logic                    dmemWrite;
        logic                    dmemEn;
        logic                    memToReg;
        logic                    dump;
        logic [RegAddrWidth-1:0] rdAddr;
    } exMemT;

endpackage

// File: rtl/ex_mem_reg.sv
// Execute-to-memory stage register; loads only when captureEn is high.
// Part of the mem_stage slice (feature macro MEM_ALIGN_CHK_EN not used here).
module ex_mem_reg
    import mem_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  captureEn,
    input  exMemT d,
    output exMemT q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (captureEn) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one op, issues the data-memory request, writes back.
// Define MEM_ALIGN_CHK_EN to reject odd-address memory ops and expose AlignErr.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ValidIn,
    input  logic [DataWidth-1:0]    AluResIn,
    input  logic [DataWidth-1:0]    RtIn,
    input  logic                    RegWriteIn,
    input  logic                    DMemWriteIn,
    input  logic                    DMemEnIn,
    input  logic                    MemToRegIn,
    input  logic                    DMemDumpIn,
    input  logic [RegAddrWidth-1:0] RdAddrIn,
    output logic                    MemReq,
    output logic                    MemWr,
    output logic [DataWidth-1:0]    MemAddr,
    output logic [DataWidth-1:0]    MemWData,
    input  logic [DataWidth-1:0]    MemRData,
    input  logic                    MemReady,
    output logic                    Stall,
    output logic                    ValidOut,
    output logic                    RegWriteOut,
    output logic                    DumpOut,
`ifdef MEM_ALIGN_CHK_EN
    output logic                    AlignErr,
`endif
    output logic [DataWidth-1:0]    WbData,
    output logic [RegAddrWidth-1:0] RdAddrOut
);

    stateT state;
    exMemT stageD;
    exMemT stageQ;
    logic  busy;
    logic  isMemOp;
    logic  misaligned;
    logic  capture;
    logic  complete;

    assign stageD = '{aluRes: AluResIn, rt: RtIn, regWrite: RegWriteIn,
                      dmemWrite: DMemWriteIn, dmemEn: DMemEnIn,
                      memToReg: MemToRegIn, dump: DMemDumpIn, rdAddr: RdAddrIn};

    ex_mem_reg exMemReg (
        .clk       (clk),
        .rst       (rst),
        .captureEn (capture),
        .d         (stageD),
        .q         (stageQ)
    );

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = stageQ.dmemEn & stageQ.aluRes[0];
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned op is treated as non-memory so it completes in ACTIVE.
    assign busy     = (state == ACTIVE) || (state == WAIT);
    assign isMemOp  = stageQ.dmemEn & ~misaligned;
    assign MemReq   = busy & isMemOp;
    assign MemWr    = MemReq & stageQ.dmemWrite;
    assign MemAddr  = stageQ.aluRes;
    assign MemWData = stageQ.rt;
    assign Stall    = MemReq & ~MemReady;
    assign complete = busy & ~Stall;
    assign capture  = ValidIn & ~Stall;

    // State transitions and the writeback output register share one block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ValidOut    <= 1'b0;
            RegWriteOut <= 1'b0;
            DumpOut     <= 1'b0;
            WbData      <= '0;
            RdAddrOut   <= '0;
`ifdef MEM_ALIGN_CHK_EN
            AlignErr    <= 1'b0;
`endif
        end else begin
            if (capture) begin
                state <= ACTIVE;
            end else if (busy && !complete) begin
                state <= WAIT;
            end else if (complete) begin
                state <= IDLE;
            end

            ValidOut    <= complete;
            RegWriteOut <= complete & stageQ.regWrite & ~misaligned;
            DumpOut     <= complete & stageQ.dump;
`ifdef MEM_ALIGN_CHK_EN
            AlignErr    <= complete & misaligned;
`endif
            if (complete) begin
                WbData    <= (stageQ.memToReg && isMemOp) ? MemRData : stageQ.aluRes;
                RdAddrOut <= stageQ.rdAddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Honours MEM_ALIGN_CHK_EN for the odd-address scenario.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidIn;
    logic [15:0] AluResIn;
    logic [15:0] RtIn;
    logic        RegWriteIn;
    logic        DMemWriteIn;
    logic        DMemEnIn;
    logic        MemToRegIn;
    logic        DMemDumpIn;
    logic [2:0]  RdAddrIn;
    logic        MemReq;
    logic        MemWr;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemReady;
    logic        Stall;
    logic        ValidOut;
    logic        RegWriteOut;
    logic        DumpOut;
    logic [15:0] WbData;
    logic [2:0]  RdAddrOut;
`ifdef MEM_ALIGN_CHK_EN
    logic        AlignErr;
`endif

    int vectors = 0;
    int errors  = 0;
    int reqCycles;
    int stallCycles;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ValidIn     (ValidIn),
        .AluResIn    (AluResIn),
        .RtIn        (RtIn),
        .RegWriteIn  (RegWriteIn),
        .DMemWriteIn (DMemWriteIn),
        .DMemEnIn    (DMemEnIn),
        .MemToRegIn  (MemToRegIn),
        .DMemDumpIn  (DMemDumpIn),
        .RdAddrIn    (RdAddrIn),
        .MemReq      (MemReq),
        .MemWr       (MemWr),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .MemReady    (MemReady),
        .Stall       (Stall),
        .ValidOut    (ValidOut),
        .RegWriteOut (RegWriteOut),
        .DumpOut     (DumpOut),
`ifdef MEM_ALIGN_CHK_EN
        .AlignErr    (AlignErr),
`endif
        .WbData      (WbData),
        .RdAddrOut   (RdAddrOut)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one op onto the execute-side inputs.
    task automatic applyStimulus(input logic valid, input logic [15:0] alu,
                                 input logic [15:0] rt, input logic regWr,
                                 input logic memWr, input logic memEn,
                                 input logic memToReg, input logic dump,
                                 input logic [2:0] rd);
        ValidIn     = valid;
        AluResIn    = alu;
        RtIn        = rt;
        RegWriteIn  = regWr;
        DMemWriteIn = memWr;
        DMemEnIn    = memEn;
        MemToRegIn  = memToReg;
        DMemDumpIn  = dump;
        RdAddrIn    = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        MemRData = 16'h0000;
        MemReady = 1'b0;
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        checkOutput("rstValidOut", ValidOut, 0);
        checkOutput("rstMemReq", MemReq, 0);
        checkOutput("rstStall", Stall, 0);
        checkOutput("rstWbData", WbData, 16'h0);
        checkOutput("rstRdAddr", RdAddrOut, 0);
        checkOutput("rstRegWr", RegWriteOut, 0);
        checkOutput("rstDump", DumpOut, 0);
        step();
        rst = 1'b0;
        step();

        // ALU op completes two cycles after being offered.
        applyStimulus(1, 16'h1234, 16'h0, 1, 0, 0, 0, 0, 3'd5);
        checkOutput("aluStall", Stall, 0);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        checkOutput("aluNoReq", MemReq, 0);
        checkOutput("aluEarly", ValidOut, 0);
        step();
        checkOutput("aluValid", ValidOut, 1);
        checkOutput("aluWb", WbData, 16'h1234);
        checkOutput("aluRd", RdAddrOut, 3'd5);
        checkOutput("aluRegWr", RegWriteOut, 1);
        step();
        checkOutput("aluPulse", ValidOut, 0);

        // Load with three MemReady-low cycles.
        applyStimulus(1, 16'h0040, 16'h0, 1, 0, 1, 1, 0, 3'd2);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        reqCycles = 0;
        stallCycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                MemReady = 1'b1;
                MemRData = 16'hBEEF;
                #1;
            end
            if (MemReq) reqCycles++;
            if (Stall) stallCycles++;
            checkOutput("ldAddr", MemAddr, 16'h0040);
            checkOutput("ldWr", MemWr, 0);
            step();
        end
        MemReady = 1'b0;
        MemRData = 16'h0000;
        #1;
        checkOutput("ldReqCycles", 16'(reqCycles), 16'd4);
        checkOutput("ldStallCycles", 16'(stallCycles), 16'd3);
        checkOutput("ldValid", ValidOut, 1);
        checkOutput("ldWb", WbData, 16'hBEEF);
        checkOutput("ldRd", RdAddrOut, 3'd2);
        checkOutput("ldReqDone", MemReq, 0);
        step();

        // Zero-wait store; MemReady high while idle is ignored.
        MemReady = 1'b1;
        applyStimulus(1, 16'h0010, 16'h00AA, 0, 1, 1, 0, 0, 3'd3);
        checkOutput("idleReq", MemReq, 0);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        checkOutput("stReq", MemReq, 1);
        checkOutput("stWr", MemWr, 1);
        checkOutput("stAddr", MemAddr, 16'h0010);
        checkOutput("stData", MemWData, 16'h00AA);
        checkOutput("stStall", Stall, 0);
        step();
        MemReady = 1'b0;
        #1;
        checkOutput("stValid", ValidOut, 1);
        checkOutput("stRegWr", RegWriteOut, 0);
        checkOutput("stReqDone", MemReq, 0);
        step();

        // ALU, load with one wait, ALU back to back.
        applyStimulus(1, 16'h1111, 16'h0, 1, 0, 0, 0, 0, 3'd1);
        step();
        applyStimulus(1, 16'h0020, 16'h0, 1, 0, 1, 1, 0, 3'd4);
        checkOutput("b2bStallA", Stall, 0);
        step();
        applyStimulus(1, 16'h3333, 16'h0, 1, 0, 0, 0, 0, 3'd6);
        checkOutput("b2bValidA", ValidOut, 1);
        checkOutput("b2bWbA", WbData, 16'h1111);
        checkOutput("b2bRdA", RdAddrOut, 3'd1);
        checkOutput("b2bStallB", Stall, 1);
        step();
        MemReady = 1'b1;
        MemRData = 16'h5555;
        #1;
        checkOutput("b2bGap", ValidOut, 0);
        checkOutput("b2bAddrB", MemAddr, 16'h0020);
        checkOutput("b2bStallFree", Stall, 0);
        step();
        MemReady = 1'b0;
        MemRData = 16'h0000;
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        checkOutput("b2bValidB", ValidOut, 1);
        checkOutput("b2bWbB", WbData, 16'h5555);
        checkOutput("b2bRdB", RdAddrOut, 3'd4);
        step();
        checkOutput("b2bValidC", ValidOut, 1);
        checkOutput("b2bWbC", WbData, 16'h3333);
        checkOutput("b2bRdC", RdAddrOut, 3'd6);
        step();
        checkOutput("b2bNoDup", ValidOut, 0);

        // Reset while the load waits for memory.
        applyStimulus(1, 16'h0050, 16'h0, 1, 0, 1, 1, 0, 3'd7);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        step();
        checkOutput("waitReq", MemReq, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstDropReq", MemReq, 0);
        checkOutput("rstDropStall", Stall, 0);
        step();
        rst = 1'b0;
        MemReady = 1'b1;
        MemRData = 16'hDEAD;
        step();
        checkOutput("rstNoValid1", ValidOut, 0);
        step();
        checkOutput("rstNoValid2", ValidOut, 0);
        MemReady = 1'b0;
        applyStimulus(1, 16'h0ABC, 16'h0, 1, 0, 0, 0, 0, 3'd2);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        step();
        checkOutput("postRstValid", ValidOut, 1);
        checkOutput("postRstWb", WbData, 16'h0ABC);
        step();

        // Dump op without memory enable.
        applyStimulus(1, 16'h7777, 16'h0, 0, 0, 0, 0, 1, 3'd0);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        checkOutput("dumpNoReq", MemReq, 0);
        checkOutput("dumpEarly", DumpOut, 0);
        step();
        checkOutput("dumpPulse", DumpOut, 1);
        checkOutput("dumpValid", ValidOut, 1);
        step();
        checkOutput("dumpOnce", DumpOut, 0);

        // Odd-address load.
        applyStimulus(1, 16'h0041, 16'h0, 1, 0, 1, 1, 0, 3'd3);
        step();
        applyStimulus(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
`ifdef MEM_ALIGN_CHK_EN
        checkOutput("alignNoReq", MemReq, 0);
        step();
        checkOutput("alignValid", ValidOut, 1);
        checkOutput("alignErr", AlignErr, 1);
        checkOutput("alignRegWr", RegWriteOut, 0);
        step();
        checkOutput("alignErrPulse", AlignErr, 0);
`else
        checkOutput("oddReq", MemReq, 1);
        checkOutput("oddAddr", MemAddr, 16'h0041);
        MemReady = 1'b1;
        MemRData = 16'h4242;
        #1;
        step();
        MemReady = 1'b0;
        #1;
        checkOutput("oddValid", ValidOut, 1);
        checkOutput("oddWb", WbData, 16'h4242);
        checkOutput("oddRegWr", RegWriteOut, 1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
